csla_bec_pipe: RTL
==================

# csla_bec_pipe

Parametrised, pipelined carry-select adder with binary-to-excess-1 (BEC) groups and a valid/ready handshake. It generalises the fixed 16-bit carry-select/BEC adder to any width, group size and pipeline depth. It is the registered accumulation adder feeding the recursive Karatsuba multiplier's partial-product combine stage. Carry propagates group to group and is cut by registers at stage boundaries, so WIDTH can grow without growing the critical path.

## Interface
Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of GROUP, minimum 8.
- GROUP, 4, bits per carry-select group. Group 0 is a plain ripple-carry adder; every other group is an RCA with cin=0 plus a BEC (+1) selected by the incoming carry.
- STAGES, 2, pipeline register stages; 1 ≤ STAGES ≤ WIDTH/GROUP.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in.
- in_valid  in  1  a/b/cin valid this cycle.
- in_ready  out  1  block accepts the input this cycle.
- sum  out  WIDTH  registered result.
- cout  out  1  registered carry out.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  downstream accepts the result.
- ovf  out  1  signed overflow. Present only with CSLA_OVF_EN.

## Operation
- NG = WIDTH/GROUP groups, partitioned into STAGES contiguous segments, LSB first.
- Each segment holds ceil(NG/STAGES) groups. The last segment takes the remainder.
- Stage s evaluates its segment's groups from the carry registered by stage s-1 (stage 0 uses cin).
- Stage s registers:
  - the sum bits completed so far;
  - the segment's carry out;
  - the still-unused upper bits of a and b;
  - valid_s.
- Result is exact: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No saturation.
- Handshake:
  - A transfer happens when valid and ready are both high on the same rising edge.
  - ready_s = !valid_s || ready_(s+1); the final stage's ready_(s+1) is out_ready.
  - in_ready = ready_0. This ready chain is combinational, so bubbles are squeezed out.
- Stalled stages hold their data unchanged. out_valid=1 with out_ready=0 keeps sum/cout/ovf stable until accepted.
- Ordering is strictly FIFO. Capacity is exactly STAGES transactions.
- Reset:
  - All valid_s, sum, cout and ovf registers go to 0; out_valid=0.
  - in_ready reads 1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight transactions silently.
- in_valid=0 never modifies stage data. Data registers load only on transfer.
- If in_valid rises while in_ready=0, the source must hold a/b/cin stable. The block does not sample them until in_ready=1.

## Timing
- Latency: a result accepted at edge k appears with out_valid=1 after edge k+STAGES-1 registers it into the last stage. That is, out_valid is visible STAGES cycles after the input cycle.
- Throughput: one transaction per cycle while out_ready=1.
- Critical path: ceil(NG/STAGES) groups of (GROUP-bit RCA, BEC, 2:1 mux), plus the ready chain across STAGES.
- Simultaneous accept at input and output when full: allowed. The pipeline shifts and occupancy is unchanged.
- Full, i.e. all valid_s=1 and out_ready=0: in_ready=0.
- Empty: out_valid=0; sum/cout hold their last value (0 after reset).

## Configuration
- CSLA_OVF_EN defined:
  - Port ovf exists.
  - ovf = carry into MSB XOR cout, registered alongside sum. Reset 0.
  - Follows the same handshake/stall rules as sum.
- CSLA_OVF_EN undefined: ovf port and its register are absent. Everything else is identical.

## Test plan
Run with WIDTH=32, GROUP=4, STAGES=2 unless stated.
- Basic: a=0000FFFF, b=00000001, cin=0, out_ready=1 → sum=00010000, cout=0, out_valid 2 cycles after input.
- Full carry: a=b=FFFFFFFF, cin=1 → sum=FFFFFFFF, cout=1. Then a=FFFFFFFF, b=0, cin=1 → sum=00000000, cout=1, exercising the carry across the stage boundary.
- Backpressure: out_ready=0, offer 3 back-to-back inputs (1+1, 2+2, 3+3) → exactly 2 accepted, then in_ready=0. On releasing out_ready, outputs are 2, 4, 6 in order, each held stable while stalled.
- Reset mid-op: accept two transactions, assert rst one cycle → out_valid=0, sum=0, cout=0. No stale result ever emerges.
- Parameter sweep: WIDTH=16/STAGES=1 and WIDTH=64/GROUP=8/STAGES=8, random vectors → match a+b+cin; latency equals STAGES.
- CSLA_OVF_EN: a=7FFFFFFF, b=00000001 → ovf=1. a=80000000, b=80000000 → ovf=1, cout=1, sum=0. a=5, b=3 → ovf=0.

Source files
------------

// File: rtl/csla_bec_pipe.sv
// rtl/csla_bec_pipe.sv - pipelined carry-select adder with BEC groups and valid/ready handshake
// Optional registered signed-overflow output ovf is enabled by defining CSLA_OVF_EN.
module csla_bec_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef CSLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG  = WIDTH / GROUP;
  localparam int GPS = (NG + STAGES - 1) / STAGES;
  localparam int MS  = (NG - 1) / GPS;

  function automatic int seg_hi(input int s);
    int g;
    g = (s + 1) * GPS;
    if (g > NG) g = NG;
    return g * GROUP;
  endfunction

  function automatic int seg_lo(input int s);
    return (s == 0) ? 0 : seg_hi(s - 1);
  endfunction

  // Each boundary slot in cb_q packs {b bits not yet added, carry}.
  function automatic int cb_off(input int s);
    int o;
    o = 0;
    for (int t = 0; t < s; t++) o += WIDTH - seg_hi(t) + 1;
    return o;
  endfunction

  localparam int CBT = cb_off(STAGES);

  // x_q holds {a bits not yet added, sum bits completed so far}.
  logic [WIDTH-1:0]  x_q [STAGES];
  logic [CBT-1:0]    cb_q;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] rdy;

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      logic r;
      r = out_ready;
      for (int t = s; t < STAGES; t++) r = r | ~valid_q[t];
      rdy[s] = r;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = x_q[STAGES-1];
  assign cout      = cb_q[CBT-1];

`ifdef CSLA_OVF_EN
  logic [STAGES-1:MS] ovf_q;
  assign ovf = ovf_q[STAGES-1];
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO  = seg_lo(s);
    localparam int HI  = seg_hi(s);
    localparam int NGS = (HI - LO) / GROUP;

    logic [WIDTH-1:0]  x_in;
    logic [WIDTH-1:0]  x_nxt;
    logic [WIDTH-LO:0] cb_in;
    logic [WIDTH-HI:0] cb_nxt;
    logic              v_in;
    logic              c_out;

    if (s == 0) begin : g_src
      assign x_in  = a;
      assign cb_in = {b, cin};
      assign v_in  = in_valid;
    end else begin : g_src
      assign x_in  = x_q[s-1];
      assign cb_in = cb_q[cb_off(s-1) +: WIDTH-LO+1];
      assign v_in  = valid_q[s-1];
    end

    always_comb begin
      logic [GROUP-1:0] ag, bg, s0, s1;
      logic             c, c0, c1;
      ag = '0;
      bg = '0;
      s0 = '0;
      s1 = '0;
      c0 = 1'b0;
      c1 = 1'b0;
      x_nxt = x_in;
      c = cb_in[0];
      for (int g = 0; g < NGS; g++) begin
        ag = x_in[LO + g*GROUP +: GROUP];
        bg = cb_in[1 + g*GROUP +: GROUP];
        if (LO == 0 && g == 0) begin
          {c, s0} = {1'b0, ag} + {1'b0, bg} + {{GROUP{1'b0}}, c};
        end else begin
          // Speculate cin=0, then the excess-1 copy covers cin=1.
          {c0, s0} = {1'b0, ag} + {1'b0, bg};
          s1 = s0 + GROUP'(1);
          c1 = c0 | (&s0);
          if (c) begin
            s0 = s1;
            c  = c1;
          end else begin
            c  = c0;
          end
        end
        x_nxt[LO + g*GROUP +: GROUP] = s0;
      end
      c_out = c;
    end

    if (HI < WIDTH) begin : g_cb
      assign cb_nxt = {cb_in[WIDTH-LO:HI-LO+1], c_out};
    end else begin : g_cb
      assign cb_nxt = c_out;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[s]                     <= 1'b0;
        x_q[s]                         <= '0;
        cb_q[cb_off(s) +: WIDTH-HI+1]  <= '0;
      end else if (rdy[s]) begin
        valid_q[s] <= v_in;
        if (v_in) begin
          x_q[s]                        <= x_nxt;
          cb_q[cb_off(s) +: WIDTH-HI+1] <= cb_nxt;
        end
      end
    end

`ifdef CSLA_OVF_EN
    if (s >= MS) begin : g_ovf
      logic ovf_nxt;
      if (s == MS) begin : g_src
        // carry into MSB is a^b^sum at that bit
        assign ovf_nxt = x_in[WIDTH-1] ^ cb_in[WIDTH-LO] ^ x_nxt[WIDTH-1] ^ c_out;
      end else begin : g_src
        assign ovf_nxt = ovf_q[s-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q[s] <= 1'b0;
        end else if (rdy[s] && v_in) begin
          ovf_q[s] <= ovf_nxt;
        end
      end
    end
`endif
  end

endmodule
